// File: rtl/mult_div_ctrl.sv
// Sequenced HI/LO multiply/divide engine: radix-2 Booth MULT, restoring DIV, one bit per clock.
// Optional MULTDIV_UNSIGNED_EN adds unsigned_op_i for MULTU/DIVU.
module mult_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mult_i,
    input  logic             start_div_i,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             unsigned_op_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DFIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               uns_q;

    // Booth datapath; two guard bits keep acc +/- mcand from overflowing for unsigned operands
    logic [WIDTH+1:0]   acc_q;
    logic [WIDTH+1:0]   mcd_q;
    logic [WIDTH-1:0]   mpl_q;
    logic               qm1_q;

    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               negq_q;
    logic               negr_q;

    logic               uns_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH+1:0]   booth_sum;
    logic [WIDTH+1:0]   booth_acc;
    logic [WIDTH-1:0]   booth_mpl;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_op = unsigned_op_i;
`else
    assign uns_op = 1'b0;
`endif

    assign a_mag = (!uns_op && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
    assign b_mag = (!uns_op && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;

    always_comb begin
        booth_sum = acc_q;
        case ({mpl_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcd_q;
            2'b10:   booth_sum = acc_q - mcd_q;
            default: ;
        endcase
        booth_acc = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
        booth_mpl = {booth_sum[0], mpl_q[WIDTH-1:1]};

        // The true difference is below the divisor, so the low WIDTH bits are exact
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, dvs_q};
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - dvs_q) : div_shift[WIDTH-1:0];
        div_quo   = {quo_q[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            uns_q   <= 1'b0;
            acc_q   <= '0;
            mcd_q   <= '0;
            mpl_q   <= '0;
            qm1_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start_mult_i) begin
                        state_q <= S_MULT;
                        busy_q  <= 1'b1;
                        uns_q   <= uns_op;
                        acc_q   <= '0;
                        mpl_q   <= b_i;
                        qm1_q   <= 1'b0;
                        mcd_q   <= uns_op ? {2'b00, a_i} : {{2{a_i[WIDTH-1]}}, a_i};
                    end else if (start_div_i) begin
                        busy_q <= 1'b1;
                        uns_q  <= uns_op;
                        if (b_i != '0) begin
                            state_q <= S_DIV;
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            negq_q  <= !uns_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            negr_q  <= !uns_op && a_i[WIDTH-1];
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Unsigned: final step sees the zero-extension bit, so only an add of mcand<<WIDTH remains
                    if (uns_q && cnt_q == CNT_W'(WIDTH)) begin
                        hi_q    <= acc_q[WIDTH-1:0] + (qm1_q ? mcd_q[WIDTH-1:0] : '0);
                        lo_q    <= mpl_q;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        acc_q <= booth_acc;
                        mpl_q <= booth_mpl;
                        qm1_q <= mpl_q[0];
                        if (!uns_q && cnt_q == CNT_W'(WIDTH-1)) begin
                            hi_q    <= booth_acc[WIDTH-1:0];
                            lo_q    <= booth_mpl;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    rem_q <= div_rem;
                    quo_q <= div_quo;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_q <= S_DFIX;
                    end
                end
                S_DFIX: begin
                    hi_q    <= negr_q ? ('0 - rem_q) : rem_q;
                    lo_q    <= negq_q ? ('0 - quo_q) : quo_q;
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: vector table, hand-written corner sequences and random ops
// checked against a plain-arithmetic model (honours MULTDIV_UNSIGNED_EN when defined).
module tb_mult_div_ctrl;

    localparam int W = 32;
`ifdef MULTDIV_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_mult = 1'b0;
    logic         start_div = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
    logic         uns = 1'b0;
`endif
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    always #5 clk = ~clk;

    mult_div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_mult_i (start_mult),
        .start_div_i  (start_div),
`ifdef MULTDIV_UNSIGNED_EN
        .unsigned_op_i(uns),
`endif
        .a_i          (a),
        .b_i          (b),
        .busy_o       (busy),
        .done_o       (done),
        .div_zero_o   (div_zero),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    typedef struct {
        logic         m;
        logic         d;
        logic         u;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         edz;
        int           elat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: results from ordinary integer arithmetic on the captured operands
    function automatic void model(input logic m, input logic u, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic [W-1:0] ph,
                                  input logic [W-1:0] pl, output logic [W-1:0] eh,
                                  output logic [W-1:0] el, output logic edz, output int elat);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        edz = 1'b0;
        if (m) begin
            if (u) p = {32'b0, av} * {32'b0, bv};
            else begin
                sa = longint'($signed(av));
                sb = longint'($signed(bv));
                p  = 64'(sa * sb);
            end
            eh = p[63:32];
            el = p[31:0];
            elat = u ? W + 2 : W + 1;
        end else if (bv == '0) begin
            eh = ph; el = pl; edz = 1'b1; elat = 1;
        end else begin
            if (u) begin
                el = av / bv;
                eh = av % bv;
            end else begin
                sa = longint'($signed(av));
                sb = longint'($signed(bv));
                sq = sa / sb;
                sr = sa % sb;
                el = W'(sq);
                eh = W'(sr);
            end
            elat = W + 2;
        end
    endfunction

    task automatic exec(input logic m, input logic d, input logic u, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz, input int elat, input string tag);
        int lat;
        logic seen, held;
        @(negedge clk);
        start_mult = m; start_div = d; a = av; b = bv;
`ifdef MULTDIV_UNSIGNED_EN
        uns = u;
`else
        if (u) $display("note: %s unsigned request has no effect in signed build", tag);
`endif
        @(posedge clk);
        #1;
        start_mult = 1'b0; start_div = 1'b0;
        a = $urandom; b = $urandom;
`ifdef MULTDIV_UNSIGNED_EN
        uns = 1'($urandom);
`endif
        lat = 0; seen = 1'b0; held = 1'b1;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) chk({tag, " busy"}, 64'(busy), 64'(1));
            if (done) begin
                seen = 1'b1;
                lat = k + 1;
            end else if (hi !== prev_hi || lo !== prev_lo) begin
                held = 1'b0;
            end
        end
        chk({tag, " done_seen"}, 64'(seen), 64'(1));
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        chk({tag, " div_zero"}, 64'(div_zero), 64'(edz));
        chk({tag, " hold"}, 64'(held), 64'(1));
        @(negedge clk);
        chk({tag, " after"}, {61'b0, done, busy, div_zero}, 64'(0));
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [W-1:0] ra, rb, eh, el;
        logic rm, ru, edz;
        int elat, sel;

        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h5,        32'h2,        32'h1,        32'h2,        1'b0, 34});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h5,        32'h0,        32'h1,        32'h2,        1'b1, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 34});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0, 34});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        32'h12345678, 32'h0,        32'h0,        1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        32'h3,        32'h0,        32'h0,        1'b0, 34});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h64,       32'h7,        32'h2,        32'hE,        1'b0, 34});
`ifdef MULTDIV_UNSIGNED_EN
        vecs.push_back('{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        1'b0, 34});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'h2,        32'h1,        32'h7FFFFFFC, 1'b0, 34});
`endif

        #23;
        chk("reset outputs", {hi, lo}, 64'(0));
        chk("reset flags", {61'b0, busy, done, div_zero}, 64'(0));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            exec(vecs[i].m, vecs[i].d, vecs[i].u, vecs[i].av, vecs[i].bv, vecs[i].eh,
                 vecs[i].el, vecs[i].edz, vecs[i].elat, $sformatf("vec%0d", i));

        // Both starts together, a stray start_div mid-run and another in the DONE cycle
        @(negedge clk);
        start_mult = 1'b1; start_div = 1'b1; a = 32'd6; b = 32'd4;
        @(posedge clk);
        #1;
        start_mult = 1'b0; start_div = 1'b0;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            start_div = 1'b0;
            if (k == 9) begin
                start_div = 1'b1; a = 32'd9; b = 32'd3;
            end
            if (done) begin
                dones++;
                chk("both lat", 64'(k + 1), 64'(33));
                chk("both result", {hi, lo}, {32'd0, 32'd24});
                start_div = 1'b1; a = 32'd50; b = 32'd0;
            end
        end
        start_div = 1'b0;
        chk("both dones", 64'(dones), 64'(1));
        chk("both busy idle", 64'(busy), 64'(0));
        prev_hi = 32'd0;
        prev_lo = 32'd24;

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            ra = (sel < 2) ? 32'h80000000 : (sel == 2) ? 32'hFFFFFFFF : W'($urandom);
            sel = int'($urandom_range(0, 9));
            rb = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'h80000000
                 : (sel < 5) ? W'($urandom_range(1, 20)) : W'($urandom);
            rm = 1'($urandom);
            ru = UNS_EN ? 1'($urandom) : 1'b0;
            model(rm, ru, ra, rb, prev_hi, prev_lo, eh, el, edz, elat);
            exec(rm, !rm, ru, ra, rb, eh, el, edz, elat, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a divide
        @(negedge clk);
        start_div = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start_div = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst outputs", {hi, lo}, 64'(0));
        chk("midrst flags", {61'b0, busy, done, div_zero}, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst no done", 64'(dones), 64'(0));
        prev_hi = '0;
        prev_lo = '0;
        exec(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
